ultrasonic_sequencer: RTL and testbench

Measurement sequencer for the HC-SR04-style ultrasonic ranging path. It periodically fires the 10 µs trigger pulse and synchronises the asynchronous echo return. It measures echo width in clock cycles with a timeout, then publishes one result per measurement cycle. Each result carries a near-window classification (1 cm to 5 cm) that drives the proximity LED. It sits between the sensor pins and the game logic and owns all trigger/echo timing. Downstream blocks only see `meas_valid` results.

---
 rtl/ultra_pkg.sv | 20 ++
 rtl/echo_sync.sv | 29 ++
 rtl/ultrasonic_sequencer.sv | 136 +++++++++++++
 tb/tb_ultrasonic_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ultra_pkg.sv
// Shared constants and state encoding for the ultrasonic ranging path.
// The distance/LED logic reuses the clock and per-centimetre scale.
package ultra_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam int unsigned CLK_HZ             = 50_000_000;
    localparam int unsigned CYCLES_PER_CM      = 2950;
    localparam int unsigned DEF_TRIG_CYCLES    = 500;
    localparam int unsigned DEF_PERIOD_CYCLES  = 3_000_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_250_000;
    localparam int unsigned DEF_CNT_W          = 22;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the raw echo pin, plus a registered previous
// value so that rising and falling edges are single-cycle qualifiers.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic echo_s,
    output logic echo_rise,
    output logic echo_fall
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], echo};
            prev <= sync[1];
        end
    end

    assign echo_s    = sync[1];
    assign echo_rise = sync[1] & ~prev;
    assign echo_fall = ~sync[1] & prev;

endmodule

// File: rtl/ultrasonic_sequencer.sv
// Periodic trigger / echo-width measurement sequencer for an HC-SR04 style
// sensor. Publishes one width-or-timeout result per measurement period.
module ultrasonic_sequencer
    import ultra_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned NEAR_MIN       = CYCLES_PER_CM,
    parameter int unsigned NEAR_MAX       = 5 * CYCLES_PER_CM,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_cycles,
    output logic             timeout,
    output logic             near,
    output logic             led
);

    // Counters start at 0 on entry, so "reached N" is seen as N-1 on the
    // edge that performs the N-th cycle's transition.
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] NMIN      = CNT_W'(NEAR_MIN);
    localparam logic [CNT_W-1:0] NMAX      = CNT_W'(NEAR_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] trig_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] width_cnt;
    logic             echo_s;
    logic             echo_rise;
    logic             echo_fall;
    logic             width_near;
    logic             tmo_hit;

    echo_sync u_echo_sync (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo),
        .echo_s    (echo_s),
        .echo_rise (echo_rise),
        .echo_fall (echo_fall)
    );

    assign width_near = (width_cnt > NMIN) && (width_cnt < NMAX);
    assign tmo_hit    = (tmo_cnt >= TMO_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            period_cnt  <= '0;
            trig_cnt    <= '0;
            tmo_cnt     <= '0;
            width_cnt   <= '0;
            trig        <= 1'b0;
            meas_valid  <= 1'b0;
            meas_cycles <= '0;
            timeout     <= 1'b0;
            near        <= 1'b0;
            led         <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            period_cnt <= sat_inc(period_cnt);
            case (state)
                IDLE, HOLDOFF: begin
                    if (state == IDLE || period_cnt >= PER_LAST) begin
                        if (enable) begin
                            state      <= TRIG;
                            trig       <= 1'b1;
                            period_cnt <= '0;
                            trig_cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                TRIG: begin
                    if (trig_cnt >= TRIG_LAST) begin
                        state   <= WAIT_RISE;
                        trig    <= 1'b0;
                        tmo_cnt <= '0;
                    end else begin
                        trig_cnt <= sat_inc(trig_cnt);
                    end
                end
                WAIT_RISE, MEASURE: begin
                    tmo_cnt <= sat_inc(tmo_cnt);
                    // A completed echo beats a coincident timeout; a coincident
                    // rise does not.
                    if (state == MEASURE && echo_fall) begin
                        state       <= HOLDOFF;
                        meas_valid  <= 1'b1;
                        meas_cycles <= width_cnt;
                        timeout     <= 1'b0;
                        near        <= width_near;
                        led         <= width_near;
                    end else if (tmo_hit) begin
                        state       <= HOLDOFF;
                        meas_valid  <= 1'b1;
                        meas_cycles <= TMO_VAL;
                        timeout     <= 1'b1;
                        near        <= 1'b0;
                        led         <= 1'b0;
                    end else if (state == WAIT_RISE) begin
                        if (echo_rise) begin
                            state     <= MEASURE;
                            width_cnt <= CNT_W'(1);
                        end
                    end else if (echo_s) begin
                        width_cnt <= sat_inc(width_cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                    trig  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_sequencer.sv
// Randomized echo-width bench with a timing-rule reference model, using
// scaled-down parameters so several full measurement periods fit.
module tb_ultrasonic_sequencer;

    localparam int T    = 10;
    localparam int P    = 500;
    localparam int TO   = 400;
    localparam int NMIN = 30;
    localparam int NMAX = 150;
    localparam int CW   = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          echo;
    logic          trig;
    logic          busy;
    logic          meas_valid;
    logic [CW-1:0] meas_cycles;
    logic          timeout;
    logic          near;
    logic          led;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int tf, tr, prev_tr;

    ultrasonic_sequencer #(
        .TRIG_CYCLES    (T),
        .PERIOD_CYCLES  (P),
        .TIMEOUT_CYCLES (TO),
        .NEAR_MIN       (NMIN),
        .NEAR_MAX       (NMAX),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .busy        (busy),
        .meas_valid  (meas_valid),
        .meas_cycles (meas_cycles),
        .timeout     (timeout),
        .near        (near),
        .led         (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig_rise();
        int k = 0;
        while (trig !== 1'b1 && k < 2 * P) begin
            tick();
            k++;
        end
        chk("trig_rise", trig, 1);
        tr = cyc;
        if (prev_tr >= 0) chk("period", tr - prev_tr, P);
        prev_tr = tr;
    endtask

    task automatic wait_trig_fall();
        int k = 0;
        while (trig === 1'b1 && k < 2 * T) begin
            chk("busy_trig", busy, 1);
            tick();
            k++;
        end
        chk("trig_width", k, T);
        tf = cyc;
    endtask

    // Echo raised d cycles after trig fall, held w cycles (w=0: never).
    // Result lands 3 edges after the raw fall unless the timeout edge
    // (TO cycles after trig fall) comes first.
    task automatic run_meas(input int d, input int w, input bit drop);
        int exp_at, exp_c, got_at, got_c, nv, j;
        bit exp_t, exp_n, got_t, got_n, got_l;
        while (cyc < tf + d) tick();
        chk("busy_meas", busy, 1);
        if (w > 0 && d + w + 3 <= TO) begin
            exp_t = 0; exp_c = w; exp_at = tf + d + w + 3;
        end else begin
            exp_t = 1; exp_c = TO; exp_at = tf + TO;
        end
        exp_n = !exp_t && (w > NMIN) && (w < NMAX);
        if (w > 0) echo = 1'b1;
        nv = 0; got_at = -1; j = 0;
        got_c = 0; got_t = 0; got_n = 0; got_l = 0;
        for (int k = 0; k < 2 * P && !(cyc >= tf + TO + 4 && j >= w); k++) begin
            tick();
            j++;
            if (w > 0 && j == w) echo = 1'b0;
            if (drop && j == w / 2) enable = 1'b0;
            if (meas_valid === 1'b1) begin
                nv++;
                if (got_at < 0) begin
                    got_at = cyc; got_c = meas_cycles;
                    got_t = timeout; got_n = near; got_l = led;
                end
            end
        end
        chk("n_valid", nv, 1);
        chk("valid_at", got_at - tf, exp_at - tf);
        chk("meas_cycles", got_c, exp_c);
        chk("timeout", got_t, exp_t);
        chk("near", got_n, exp_n);
        chk("led", got_l, exp_n);
        chk("held_cycles", meas_cycles, exp_c);
    endtask

    initial begin
        int dd[9] = '{5, 5, 5, 5, 0, 10, 10, 397, 0};
        int ww[9] = '{90, 30, 150, 200, 0, TO - 13, TO - 12, 5, 1};
        int c0, d, w, nt;
        rst = 1'b1; enable = 1'b0; echo = 1'b0; prev_tr = -1;
        tick(); tick();
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_cycles", meas_cycles, 0);
        chk("rst_flags", {timeout, near, led}, 0);
        rst = 1'b0;
        tick();
        c0 = cyc;
        enable = 1'b1;
        wait_trig_rise();
        chk("en_to_trig", tr - c0, 1);

        foreach (dd[i]) begin
            if (i > 0) wait_trig_rise();
            wait_trig_fall();
            run_meas(dd[i], ww[i], 1'b0);
        end

        // Stale echo high across the end of the trigger pulse.
        wait_trig_rise();
        echo = 1'b1;
        wait_trig_fall();
        repeat (30) tick();
        echo = 1'b0;
        run_meas(50, 40, 1'b0);

        for (int i = 0; i < 12; i++) begin
            d = $urandom_range(0, 40);
            case ($urandom_range(0, 3))
                0: w = $urandom_range(NMIN - 2, NMIN + 2);
                1: w = $urandom_range(NMAX - 2, NMAX + 2);
                2: w = $urandom_range(TO - d - 8, TO - d + 2);
                default: w = $urandom_range(1, 200);
            endcase
            wait_trig_rise();
            wait_trig_fall();
            run_meas(d, w, 1'b0);
        end

        // Enable drops mid-measurement: result still lands, then idle.
        wait_trig_rise();
        wait_trig_fall();
        run_meas(10, 80, 1'b1);
        while (cyc < tr + P - 1) tick();
        chk("busy_holdoff", busy, 1);
        tick();
        chk("busy_idle", busy, 0);
        nt = 0;
        repeat (2 * P) begin
            tick();
            if (trig === 1'b1) nt++;
        end
        chk("no_trig", nt, 0);

        // Reset in the middle of a trigger pulse.
        prev_tr = -1;
        enable = 1'b1;
        wait_trig_rise();
        repeat (3) tick();
        chk("trig_pre_rst", trig, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_trig", trig, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", meas_valid, 0);
        chk("mid_rst_cycles", meas_cycles, 0);
        chk("mid_rst_flags", {timeout, near, led}, 0);
        rst = 1'b0; enable = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
